execute_stage_fwd_mul: RTL and testbench

//  Parametrised EX stage of the 5-stage RV32I core. Adds operand forwarding,

---
 rtl/execute_stage_fwd_mul_pkg.sv | 35 +++
 rtl/execute_stage_fwd_mul_mul_iter.sv | 83 ++++++++
 rtl/execute_stage_fwd_mul.sv | 172 +++++++++++++++++
 tb/tb_execute_stage_fwd_mul.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_fwd_mul_pkg.sv
// Shared encodings for the RV32I execute stage: ALU ops, forward selects,
// branch conditions and the iterative multiplier state.
package exe_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_WB     = 2'b01;
  localparam logic [1:0] FWD_MEM    = 2'b10;
  localparam logic [1:0] FWD_RF_ALT = 2'b11;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/execute_stage_fwd_mul_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low XLEN
// bits of the product. DONE is held while the consumer (hold) is stalled.
module mul_iter
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);

  mul_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MUL_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (state_q == MUL_IDLE && start) begin
      cnt_q    <= CNT_INIT;
      acc_q    <= '0;
      mcand_q  <= opa;
      mplier_q <= opb;
    end else if (state_q == MUL_RUN) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUL_IDLE: if (start && !abort) state_d = MUL_RUN;
      MUL_RUN: begin
        if (abort)                   state_d = MUL_IDLE;
        else if (cnt_q == CW'(1))    state_d = MUL_DONE;
      end
      MUL_DONE: if (abort || !hold)  state_d = MUL_IDLE;
      default:                       state_d = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      MUL_IDLE: busy = start && !abort;
      MUL_RUN:  busy = !abort;
      MUL_DONE: done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  assign product = acc_q;

endmodule

// File: rtl/execute_stage_fwd_mul.sv
// EX stage: operand forwarding, ALU, branch/jump resolution, iterative MUL
// and the EX/MEM pipeline register with stall/flush control.
module execute_stage_fwd_mul
  import exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_e,
  input  logic              flush_e_i,
  input  logic              stall_m_i,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ALUSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              JalrE,
  input  logic [1:0]        ResultSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [2:0]        Funct3E,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   ResultW,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              stall_e_o,
  output logic              valid_m,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ALU_ResultM
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_res, product, jalr_sum;
  logic [SHW-1:0]  shamt;
  logic            is_mul, mul_start, mul_busy, mul_done, br_cond, bubble;

  always_comb begin
    fwd_a = RD1_E;
    unique case (ForwardAE)
      FWD_RF, FWD_RF_ALT: fwd_a = RD1_E;
      FWD_WB:             fwd_a = ResultW;
      FWD_MEM:            fwd_a = ALU_ResultM;
      default:            fwd_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    unique case (ForwardBE)
      FWD_RF, FWD_RF_ALT: fwd_b = RD2_E;
      FWD_WB:             fwd_b = ResultW;
      FWD_MEM:            fwd_b = ALU_ResultM;
      default:            fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      ALU_ADD:  alu_res = fwd_a + src_b;
      ALU_SUB:  alu_res = fwd_a - src_b;
      ALU_AND:  alu_res = fwd_a & src_b;
      ALU_OR:   alu_res = fwd_a | src_b;
      ALU_XOR:  alu_res = fwd_a ^ src_b;
      ALU_SLT:  alu_res = XLEN'($signed(fwd_a) < $signed(src_b));
      ALU_SLTU: alu_res = XLEN'(fwd_a < src_b);
      ALU_SLL:  alu_res = fwd_a << shamt;
      ALU_SRL:  alu_res = fwd_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> shamt);
      ALU_MUL:  alu_res = product;
      default:  alu_res = '0;
    endcase
  end

  // Branch compare uses the forwarded register operands, never the immediate.
  always_comb begin
    br_cond = 1'b0;
    case (Funct3E)
      BR_EQ:   br_cond = (fwd_a == fwd_b);
      BR_NE:   br_cond = (fwd_a != fwd_b);
      BR_LT:   br_cond = ($signed(fwd_a) < $signed(fwd_b));
      BR_GE:   br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  br_cond = (fwd_a < fwd_b);
      BR_GEU:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = valid_e && !flush_e_i && (JumpE || (BranchE && br_cond));
  assign jalr_sum  = fwd_a + Imm_Ext_E;
  assign PCTargetE = JalrE ? (jalr_sum & ~XLEN'(1)) : (PCE + Imm_Ext_E);

  assign is_mul    = (MUL_EN != 1'b0) && (ALUControlE == ALU_MUL);
  assign mul_start = valid_e && is_mul;

  generate
    if (MUL_EN) begin : g_mul
      mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (flush_e_i),
        .hold    (stall_m_i),
        .opa     (fwd_a),
        .opb     (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign product  = '0;
    end
  endgenerate

  assign stall_e_o = stall_m_i || mul_busy;
  assign bubble    = flush_e_i || !valid_e || (is_mul && !mul_done);

  // Downstream stall outranks flush: the register holds and the EX op is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m     <= 1'b0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= '0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (!stall_m_i) begin
      if (bubble) begin
        valid_m     <= 1'b0;
        RegWriteM   <= 1'b0;
        MemWriteM   <= 1'b0;
        ResultSrcM  <= '0;
        RD_M        <= '0;
        PCPlus4M    <= '0;
        WriteDataM  <= '0;
        ALU_ResultM <= '0;
      end else begin
        valid_m     <= 1'b1;
        RegWriteM   <= RegWriteE;
        MemWriteM   <= MemWriteE;
        ResultSrcM  <= ResultSrcE;
        RD_M        <= RD_E;
        PCPlus4M    <= PCPlus4E;
        WriteDataM  <= fwd_b;
        ALU_ResultM <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_fwd_mul.sv
// Self-checking bench for execute_stage_fwd_mul: directed scenarios plus
// randomized ops checked against a plain-arithmetic reference model.
module tb_execute_stage_fwd_mul;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_e, flush_e_i, stall_m_i;
  logic              RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE;
  logic [1:0]        ResultSrcE;
  logic [3:0]        ALUControlE;
  logic [2:0]        Funct3E;
  logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [REG_AW-1:0] RD_E;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              PCSrcE;
  logic [XLEN-1:0]   PCTargetE;
  logic              stall_e_o;
  logic              valid_m, RegWriteM, MemWriteM;
  logic [1:0]        ResultSrcM;
  logic [REG_AW-1:0] RD_M;
  logic [XLEN-1:0]   PCPlus4M, WriteDataM, ALU_ResultM;

  always #5 clk = ~clk;

  execute_stage_fwd_mul #(.XLEN(XLEN), .REG_AW(REG_AW), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e_i(flush_e_i), .stall_m_i(stall_m_i),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
    .JumpE(JumpE), .JalrE(JalrE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .stall_e_o(stall_e_o),
    .valid_m(valid_m), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  typedef struct packed {
    logic              valid, rw, mw;
    logic [1:0]        rs;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc4, wd, alu;
  } exmem_t;

  exmem_t exp_m;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_mem(input string tag);
    check({tag, ".valid_m"},  32'(valid_m),    32'(exp_m.valid));
    check({tag, ".regwrite"}, 32'(RegWriteM),  32'(exp_m.rw));
    check({tag, ".memwrite"}, 32'(MemWriteM),  32'(exp_m.mw));
    check({tag, ".ressrc"},   32'(ResultSrcM), 32'(exp_m.rs));
    check({tag, ".rd"},       32'(RD_M),       32'(exp_m.rd));
    check({tag, ".pc4"},      PCPlus4M,        exp_m.pc4);
    check({tag, ".wdata"},    WriteDataM,      exp_m.wd);
    check({tag, ".alu"},      ALU_ResultM,     exp_m.alu);
  endtask

  // Reference model: straight from the operation definitions.
  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return 32'($signed(a) >>> sh);
      4'd10: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_exp(input logic [31:0] res, input logic [31:0] wd);
    exp_m.valid = 1'b1;
    exp_m.rw    = RegWriteE;
    exp_m.mw    = MemWriteE;
    exp_m.rs    = ResultSrcE;
    exp_m.rd    = RD_E;
    exp_m.pc4   = PCPlus4E;
    exp_m.wd    = wd;
    exp_m.alu   = res;
  endtask

  task automatic set_nop();
    valid_e = 0; flush_e_i = 0; stall_m_i = 0;
    RegWriteE = 0; MemWriteE = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0; JalrE = 0;
    ResultSrcE = 0; ALUControlE = 0; Funct3E = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RD_E = 0; ForwardAE = 0; ForwardBE = 0;
  endtask

  // One single-cycle (non-MUL) instruction through EX with the multiplier idle.
  task automatic tick(input string tag);
    logic [31:0] fa, fb, sb, res, tgt;
    logic        pcs;
    fa  = m_fwd(ForwardAE, RD1_E, ResultW, exp_m.alu);
    fb  = m_fwd(ForwardBE, RD2_E, ResultW, exp_m.alu);
    sb  = ALUSrcE ? Imm_Ext_E : fb;
    res = m_alu(ALUControlE, fa, sb);
    pcs = valid_e && !flush_e_i && (JumpE || (BranchE && m_cond(Funct3E, fa, fb)));
    tgt = JalrE ? ((fa + Imm_Ext_E) & 32'hFFFF_FFFE) : (PCE + Imm_Ext_E);
    #1;
    check({tag, ".pcsrc"},  32'(PCSrcE),    32'(pcs));
    check({tag, ".target"}, PCTargetE,      tgt);
    check({tag, ".stall"},  32'(stall_e_o), 32'(stall_m_i));
    @(posedge clk); #1;
    if (!stall_m_i) begin
      if (flush_e_i || !valid_e) exp_m = '0;
      else                       load_exp(res, fb);
    end
    check_mem(tag);
  endtask

  // Multiply of a*b; optional flush in RUN cycle flush_run, optional DONE stall cycles.
  task automatic mul_seq(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int flush_run, input int done_stalls);
    set_nop();
    valid_e = 1; ALUControlE = 4'd10; RD1_E = a; RD2_E = b; RegWriteE = 1;
    RD_E = 5'($urandom); PCPlus4E = $urandom; ResultSrcE = 2'($urandom);
    for (int c = 1; c <= 33; c++) begin
      if (flush_run != 0 && c == flush_run + 1) begin
        flush_e_i = 1;
        #1 check({tag, ".flush_stall"}, 32'(stall_e_o), 32'd0);
        @(posedge clk); #1;
        exp_m = '0;
        check_mem({tag, ".flush"});
        set_nop();
        return;
      end
      #1 check({tag, ".busy_stall"}, 32'(stall_e_o), 32'd1);
      @(posedge clk); #1;
      exp_m = '0;
      check_mem({tag, ".bubble"});
    end
    for (int s = 0; s < done_stalls; s++) begin
      stall_m_i = 1;
      #1 check({tag, ".done_hold_stall"}, 32'(stall_e_o), 32'd1);
      @(posedge clk); #1;
      check_mem({tag, ".done_hold"});
    end
    stall_m_i = 0;
    #1 check({tag, ".done_stall"}, 32'(stall_e_o), 32'd0);
    @(posedge clk); #1;
    load_exp(a * b, b);
    check_mem({tag, ".product"});
    set_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_nop();
    exp_m = '0;
    rst = 1;
    #12;
    check_mem("reset");
    check("reset.stall", 32'(stall_e_o), 32'd0);
    check("reset.pcsrc", 32'(PCSrcE), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // 1: ADD with immediate
    set_nop(); valid_e = 1; RegWriteE = 1; RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; RD_E = 5'd3;
    tick("add_imm");
    check("add_imm.const", ALU_ResultM, 32'd12);

    // 2: forwarding from MEM and WB into a SUB
    set_nop(); valid_e = 1; RD1_E = 32'h10; ALUControlE = 4'd0;
    tick("seed_mem");
    set_nop(); valid_e = 1; ALUControlE = 4'd1; ForwardAE = 2'b10; ForwardBE = 2'b01;
    ResultW = 3; RD1_E = 32'h777; RD2_E = 32'h555;
    tick("fwd_sub");
    check("fwd_sub.const", ALU_ResultM, 32'hD);
    check("fwd_sub.wdata_const", WriteDataM, 32'd3);

    // 3: BLT taken, BLTU not taken, JALR clears bit 0
    set_nop(); valid_e = 1; BranchE = 1; Funct3E = 3'b100;
    RD1_E = 32'hFFFF_FFFF; RD2_E = 1; PCE = 32'h1000; Imm_Ext_E = 32'h20;
    #1 check("blt.const_pcsrc", 32'(PCSrcE), 32'd1);
    check("blt.const_target", PCTargetE, 32'h1020);
    tick("blt");
    Funct3E = 3'b110;
    #1 check("bltu.const_pcsrc", 32'(PCSrcE), 32'd0);
    tick("bltu");
    set_nop(); valid_e = 1; JumpE = 1; JalrE = 1; RD1_E = 32'h101; Imm_Ext_E = 0;
    #1 check("jalr.const_target", PCTargetE, 32'h100);
    tick("jalr");

    // 4: full-length multiply
    mul_seq("mul_ff_3", 32'hFFFF_FFFF, 32'd3, 0, 0);
    check("mul_ff_3.const", ALU_ResultM, 32'hFFFF_FFFD);

    // 5: flush in the 10th RUN cycle, then a normal ADD
    mul_seq("mul_flush", 32'h1234_5678, 32'h9, 10, 0);
    set_nop(); valid_e = 1; RD1_E = 40; RD2_E = 2; RegWriteE = 1;
    tick("after_flush");
    check("after_flush.const", ALU_ResultM, 32'd42);

    // 6: downstream stall while DONE, then reset mid-RUN
    mul_seq("mul_done_stall", 32'd1000, 32'd1000, 0, 3);
    check("mul_done_stall.const", ALU_ResultM, 32'd1000000);
    set_nop(); valid_e = 1; ALUControlE = 4'd10; RD1_E = 7; RD2_E = 9;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
    end
    #2;
    valid_e = 0;
    rst = 1;
    exp_m = '0;
    #1;
    check_mem("rst_mid_run");
    check("rst_mid_run.stall", 32'(stall_e_o), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    set_nop(); valid_e = 1; ALUControlE = 4'd2; RD1_E = 32'hF0F0; RD2_E = 32'hFF00;
    tick("after_rst");

    // Randomized single-cycle traffic
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd10) op = op + 4'd1;
      valid_e     = ($urandom_range(0, 7) != 0);
      flush_e_i   = ($urandom_range(0, 7) == 0);
      stall_m_i   = ($urandom_range(0, 7) == 0);
      RegWriteE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      ALUSrcE     = 1'($urandom);
      BranchE     = 1'($urandom);
      JumpE       = ($urandom_range(0, 3) == 0);
      JalrE       = 1'($urandom);
      ResultSrcE  = 2'($urandom);
      ALUControlE = op;
      Funct3E     = 3'($urandom);
      RD1_E       = $urandom;
      RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
      Imm_Ext_E   = $urandom;
      PCE         = $urandom;
      PCPlus4E    = $urandom;
      ResultW     = $urandom;
      RD_E        = 5'($urandom);
      ForwardAE   = 2'($urandom);
      ForwardBE   = 2'($urandom);
      tick("rand");
    end

    // Randomized multiplies
    for (int i = 0; i < 3; i++) begin
      mul_seq("rand_mul", $urandom, $urandom, 0, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
